// File: rtl/sseg_chain_driver_if.sv
// Bus bundle between a host and the MAX7219 chain driver.
//   seg  : segment image, device c digit d = seg[c*64+(d-1)*8 +: 8]
//   upd  : refresh request, sampled every clk
//   sclk : serial clock to the device chain
//   load : LOAD/CS, devices latch their shift register on its rising edge
//   sdo  : serial data into DIN of device 0
//   busy : high while initialising or refreshing
//   done : one-cycle pulse when a refresh completes
interface sseg_chain_driver_if #(
    parameter int unsigned NCHIP = 2
);
    logic [NCHIP*64-1:0] seg;
    logic                upd;
    logic                sclk;
    logic                load;
    logic                sdo;
    logic                busy;
    logic                done;

    modport master (
        output seg, upd,
        input  sclk, load, sdo, busy, done
    );

    modport slave (
        input  seg, upd,
        output sclk, load, sdo, busy, done
    );
endinterface

// File: rtl/sseg_chain_driver.sv
// Driver for a daisy chain of MAX7219 display controllers.
// After reset it programs decode, intensity, scan limit, test-off and
// shutdown-off into every device, then repeatedly refreshes all digits from
// a latched copy of the segment image on request.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sseg_chain_driver_if.slave (seg/upd in, sclk/load/sdo/busy/done out)
module sseg_chain_driver #(
    parameter int unsigned NCHIP     = 2,
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [3:0]  INTENSITY = 4'hF,
    parameter logic [7:0]  DECODE    = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    sseg_chain_driver_if.slave bus
);

    localparam int unsigned FW = 16 * NCHIP;
    localparam int unsigned SW = 64 * NCHIP;
    localparam int unsigned BW = $clog2(FW);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LATCH,
        ST_DIG,
        ST_FIN
    } state_t;

    // Phases of one frame: START loads the shift register and drops load.
    typedef enum logic [1:0] {
        PH_START,
        PH_LOW,
        PH_HIGH,
        PH_GAP
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [3:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic [FW-1:0]   shreg_q, shreg_d;
    logic            sclk_q, sclk_d;
    logic            load_q, load_d;
    logic            sdo_q, sdo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [15:0]     init_word;
    logic [2:0]      dsel;
    logic [FW-1:0]   frame_word;
    logic            div_last;
    logic            bit_last;
    logic            frame_end;

    // Frame contents for the current state: INIT word broadcast, or one digit.
    always_comb begin : frame_build
        init_word  = 16'h0000;
        dsel       = 3'(idx_q - 4'd1);
        frame_word = '0;
        case (idx_q)
            4'd0:    init_word = {4'h0, 4'h9, DECODE};
            4'd1:    init_word = {4'h0, 4'hA, 4'h0, INTENSITY};
            4'd2:    init_word = {4'h0, 4'hB, 8'(DIGITS - 1)};
            4'd3:    init_word = 16'h0F00;
            default: init_word = 16'h0C01;
        endcase
        // Lowest word goes to device 0, so the farthest device is shifted first.
        for (int c = 0; c < int'(NCHIP); c++) begin
            if (state_q == ST_INIT) begin
                frame_word[c*16 +: 16] = init_word;
            end else begin
                frame_word[c*16 +: 16] = {4'h0, idx_q, seg_q[c*64 + int'(dsel)*8 +: 8]};
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin : next_logic
        state_d   = state_q;
        phase_d   = phase_q;
        div_d     = div_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        seg_d     = seg_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        load_d    = load_q;
        sdo_d     = sdo_q;
        frame_end = 1'b0;
        div_last  = (div_q == DW'(CLK_DIV - 1));
        bit_last  = (bit_q == BW'(FW - 1));

        // Requests arriving while busy collapse into one pending refresh.
        if (bus.upd && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        if ((state_q == ST_INIT) || (state_q == ST_DIG)) begin
            case (phase_q)
                PH_START: begin
                    shreg_d = {frame_word[FW-2:0], 1'b0};
                    sdo_d   = frame_word[FW-1];
                    load_d  = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = PH_LOW;
                end
                PH_LOW: begin
                    if (div_last) begin
                        div_d   = '0;
                        sclk_d  = 1'b1;
                        phase_d = PH_HIGH;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                PH_HIGH: begin
                    if (div_last) begin
                        div_d  = '0;
                        sclk_d = 1'b0;
                        if (bit_last) begin
                            load_d  = 1'b1;
                            sdo_d   = 1'b0;
                            phase_d = PH_GAP;
                        end else begin
                            sdo_d   = shreg_q[FW-1];
                            shreg_d = {shreg_q[FW-2:0], 1'b0};
                            bit_d   = bit_q + BW'(1);
                            phase_d = PH_LOW;
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                PH_GAP: begin
                    if (div_last) begin
                        div_d     = '0;
                        phase_d   = PH_START;
                        frame_end = 1'b1;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                default: phase_d = PH_START;
            endcase
        end

        case (state_q)
            ST_INIT: begin
                if (frame_end) begin
                    if (idx_q == 4'd4) begin
                        state_d = ST_LATCH;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.upd) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // A request in this very cycle is kept so nothing is lost.
                seg_d     = bus.seg;
                pending_d = bus.upd;
                idx_d     = 4'd1;
                phase_d   = PH_START;
                state_d   = ST_DIG;
            end
            ST_DIG: begin
                if (frame_end) begin
                    if (idx_q == 4'(DIGITS)) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_FIN: begin
                if (pending_q || bus.upd) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            state_q   <= ST_INIT;
            phase_q   <= PH_START;
            div_q     <= '0;
            bit_q     <= '0;
            idx_q     <= 4'd0;
            pending_q <= 1'b0;
            seg_q     <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b0;
            load_q    <= 1'b1;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            load_q    <= load_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.load = load_q;
    assign bus.sdo  = sdo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_sseg_chain_driver.sv
// Bench for sseg_chain_driver: two chains (8 and 4 digits) sharing clk/rst,
// each with a shift-chain model of the MAX7219 devices on its outputs.
module tb_sseg_chain_driver;

    localparam int unsigned NCHIP   = 2;
    localparam int unsigned CLK_DIV = 2;
    localparam int          TIMEOUT = 4000;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] seg_drv [2];
    logic         upd_drv [2];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned DG = (g == 0) ? 8 : 4;

        sseg_chain_driver_if #(.NCHIP(NCHIP)) bus ();
        assign bus.seg = seg_drv[g];
        assign bus.upd = upd_drv[g];

        sseg_chain_driver #(
            .NCHIP    (NCHIP),
            .DIGITS   (DG),
            .CLK_DIV  (CLK_DIV),
            .INTENSITY(4'hF),
            .DECODE   (8'h00)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        // Device chain model: shift on sclk rise, latch every device on load rise.
        logic [31:0] chain   = '0;
        int          bits    = 0;
        int          low_len = 0;
        int          hi_len  = 0;
        int          frames  = 0;
        int          aborted = 0;
        int          bad     = 0;
        int          sdo_idle = 0;
        int          dones   = 0;
        logic [15:0] seen    = '0;
        logic [7:0]  devreg [2][16] = '{default: 8'hEE};
        logic [31:0] flog [$];
        logic        sclk_p  = 1'b0;
        logic        load_p  = 1'b1;
        logic [3:0]  a;

        always @(negedge clk) begin
            if (bus.load === 1'b1 && bus.sdo !== 1'b0) sdo_idle++;
            if (bus.done === 1'b1) dones++;
            if (bus.load === 1'b0) begin
                if (load_p && hi_len < int'(CLK_DIV)) bad++;
                low_len++;
                if (bus.sclk && !sclk_p) begin
                    chain = {chain[30:0], bus.sdo};
                    bits++;
                end
            end else begin
                if (!load_p) begin
                    if (bits == 32 && low_len == 128) begin
                        frames++;
                        flog.push_back(chain);
                        for (int c = 0; c < 2; c++) begin
                            a = chain[c*16+8 +: 4];
                            if (chain[c*16+12 +: 4] != 4'h0 || a == 4'h0) bad++;
                            seen[a] = 1'b1;
                            devreg[c][a] = chain[c*16 +: 8];
                        end
                    end else begin
                        aborted++;
                    end
                    bits    = 0;
                    low_len = 0;
                    hi_len  = 0;
                end
                hi_len++;
            end
            sclk_p = bus.sclk;
            load_p = bus.load;
        end
    end

    function automatic logic [7:0] seg_byte(input logic [127:0] s, input int c, input int d);
        return s[c*64 + (d-1)*8 +: 8];
    endfunction

    function automatic logic [31:0] exp_dig(input logic [127:0] s, input int d);
        return {4'h0, 4'(d), seg_byte(s, 1, d), 4'h0, 4'(d), seg_byte(s, 0, d)};
    endfunction

    function automatic logic [7:0] exp_reg(input logic [127:0] s, input int c, input int a, input int digits);
        case (a)
            9:       return 8'h00;
            10:      return 8'h0F;
            11:      return 8'(digits - 1);
            12:      return 8'h01;
            15:      return 8'h00;
            default: return (a >= 1 && a <= digits) ? seg_byte(s, c, a) : 8'hEE;
        endcase
    endfunction

    function automatic logic [127:0] make_seg(input logic [7:0] base);
        logic [127:0] s;
        s = '0;
        for (int c = 0; c < 2; c++)
            for (int d = 1; d <= 8; d++)
                s[c*64 + (d-1)*8 +: 8] = base + 8'(16*c + d);
        return s;
    endfunction

    task automatic pulse_upd(input int g);
        upd_drv[g] = 1'b1;
        @(negedge clk);
        upd_drv[g] = 1'b0;
    endtask

    task automatic test_reset;
        logic [4:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {g_dut[0].bus.sclk, g_dut[0].bus.load, g_dut[0].bus.sdo, g_dut[0].bus.busy, g_dut[0].bus.done};
        n_checks++;
        if (obs !== 5'b01010) begin
            n_fail++;
            $display("FAIL reset_outputs_dut0: sclk/load/sdo/busy/done=%b, required 01010", obs);
        end
        obs = {g_dut[1].bus.sclk, g_dut[1].bus.load, g_dut[1].bus.sdo, g_dut[1].bus.busy, g_dut[1].bus.done};
        n_checks++;
        if (obs !== 5'b01010) begin
            n_fail++;
            $display("FAIL reset_outputs_dut1: sclk/load/sdo/busy/done=%b, required 01010", obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_init;
        int          cyc;
        logic [31:0] ini [5];
        ini[0] = 32'h09000900; ini[1] = 32'h0A0F0A0F; ini[2] = 32'h0B070B07;
        ini[3] = 32'h0F000F00; ini[4] = 32'h0C010C01;
        cyc = 0;
        while (!(g_dut[0].frames >= 5 && g_dut[1].frames >= 5) && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL init_frames_wait: frames %0d/%0d after %0d cycles, required 5", g_dut[0].frames, g_dut[1].frames, cyc);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (g_dut[0].flog[i] !== ini[i]) begin
                n_fail++;
                $display("FAIL init_frame%0d_dut0: got %h, required %h", i, g_dut[0].flog[i], ini[i]);
            end
        end
        n_checks++;
        if (g_dut[1].flog[2] !== 32'h0B030B03) begin
            n_fail++;
            $display("FAIL scan_limit_dut1: got %h, required 0b030b03", g_dut[1].flog[2]);
        end
        cyc = 0;
        while ((g_dut[0].bus.busy !== 1'b0 || g_dut[1].bus.busy !== 1'b0) && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL powerup_idle_wait: busy %b/%b after %0d cycles, required 0/0", g_dut[0].bus.busy, g_dut[1].bus.busy, cyc);
        end
        n_checks++;
        if (g_dut[0].frames !== 13 || g_dut[1].frames !== 9) begin
            n_fail++;
            $display("FAIL powerup_frame_count: got %0d/%0d, required 13/9", g_dut[0].frames, g_dut[1].frames);
        end
        n_checks++;
        if (g_dut[0].flog[12] !== 32'h083C08A5) begin
            n_fail++;
            $display("FAIL digit8_frame: got %h, required 083c08a5", g_dut[0].flog[12]);
        end
        for (int d = 1; d <= 7; d++) begin
            n_checks++;
            if (g_dut[0].flog[4+d] !== exp_dig(seg_drv[0], d)) begin
                n_fail++;
                $display("FAIL powerup_digit%0d: got %h, required %h", d, g_dut[0].flog[4+d], exp_dig(seg_drv[0], d));
            end
        end
        n_checks++;
        if (g_dut[0].dones !== 1 || g_dut[1].dones !== 1) begin
            n_fail++;
            $display("FAIL powerup_done_count: got %0d/%0d, required 1/1", g_dut[0].dones, g_dut[1].dones);
        end
        for (int c = 0; c < 2; c++)
            for (int ad = 0; ad < 16; ad++) begin
                n_checks++;
                if (g_dut[0].devreg[c][ad] !== exp_reg(seg_drv[0], c, ad, 8)) begin
                    n_fail++;
                    $display("FAIL powerup_reg dev%0d addr%h: got %h, required %h", c, ad, g_dut[0].devreg[c][ad], exp_reg(seg_drv[0], c, ad, 8));
                end
            end
    endtask

    task automatic test_back_to_back;
        int           cyc, bf, bd;
        logic [127:0] p1, p3;
        p1 = make_seg(8'h00);
        p3 = make_seg(8'h80);
        bf = g_dut[0].frames;
        bd = g_dut[0].dones;
        seg_drv[0] = p1;
        pulse_upd(0);
        repeat (5) @(negedge clk);
        seg_drv[0] = '1;
        repeat (200) @(negedge clk);
        pulse_upd(0);
        repeat (300) @(negedge clk);
        pulse_upd(0);
        seg_drv[0] = p3;
        cyc = 0;
        while (g_dut[0].bus.busy !== 1'b0 && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL b2b_idle_wait: busy %b after %0d cycles, required 0", g_dut[0].bus.busy, cyc);
        end
        n_checks++;
        if (g_dut[0].frames - bf !== 16 || g_dut[0].dones - bd !== 2) begin
            n_fail++;
            $display("FAIL b2b_counts: frames +%0d dones +%0d, required +16 +2", g_dut[0].frames - bf, g_dut[0].dones - bd);
        end
        for (int d = 1; d <= 8; d++) begin
            n_checks++;
            if (g_dut[0].flog[bf+d-1] !== exp_dig(p1, d) || g_dut[0].flog[bf+7+d] !== exp_dig(p3, d)) begin
                n_fail++;
                $display("FAIL b2b_digit%0d: got %h/%h, required %h/%h", d, g_dut[0].flog[bf+d-1], g_dut[0].flog[bf+7+d], exp_dig(p1, d), exp_dig(p3, d));
            end
        end
        for (int c = 0; c < 2; c++)
            for (int ad = 0; ad < 16; ad++) begin
                n_checks++;
                if (g_dut[0].devreg[c][ad] !== exp_reg(p3, c, ad, 8)) begin
                    n_fail++;
                    $display("FAIL b2b_reg dev%0d addr%h: got %h, required %h", c, ad, g_dut[0].devreg[c][ad], exp_reg(p3, c, ad, 8));
                end
            end
    endtask

    task automatic test_fin_request;
        int cyc, bf, bd;
        bf = g_dut[0].frames;
        bd = g_dut[0].dones;
        pulse_upd(0);
        cyc = 0;
        while (g_dut[0].bus.done !== 1'b1 && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL fin_done_wait: done %b after %0d cycles, required 1", g_dut[0].bus.done, cyc);
        end
        pulse_upd(0);
        cyc = 0;
        while (g_dut[0].bus.busy !== 1'b0 && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL fin_idle_wait: busy %b after %0d cycles, required 0", g_dut[0].bus.busy, cyc);
        end
        n_checks++;
        if (g_dut[0].frames - bf !== 16 || g_dut[0].dones - bd !== 2) begin
            n_fail++;
            $display("FAIL fin_request_counts: frames +%0d dones +%0d, required +16 +2", g_dut[0].frames - bf, g_dut[0].dones - bd);
        end
    endtask

    task automatic test_digits4;
        int           cyc, bf;
        logic [127:0] q;
        q  = make_seg(8'h40);
        bf = g_dut[1].frames;
        seg_drv[1] = q;
        pulse_upd(1);
        cyc = 0;
        while (g_dut[1].bus.busy !== 1'b0 && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL dig4_idle_wait: busy %b after %0d cycles, required 0", g_dut[1].bus.busy, cyc);
        end
        n_checks++;
        if (g_dut[1].frames - bf !== 4) begin
            n_fail++;
            $display("FAIL dig4_frame_count: got +%0d, required +4", g_dut[1].frames - bf);
        end
        for (int d = 1; d <= 4; d++) begin
            n_checks++;
            if (g_dut[1].flog[bf+d-1] !== exp_dig(q, d)) begin
                n_fail++;
                $display("FAIL dig4_digit%0d: got %h, required %h", d, g_dut[1].flog[bf+d-1], exp_dig(q, d));
            end
        end
        n_checks++;
        if (g_dut[1].seen !== 16'h9E1E) begin
            n_fail++;
            $display("FAIL dig4_addr_set: got %h, required 9e1e", g_dut[1].seen);
        end
        for (int c = 0; c < 2; c++)
            for (int ad = 0; ad < 16; ad++) begin
                n_checks++;
                if (g_dut[1].devreg[c][ad] !== exp_reg(q, c, ad, 4)) begin
                    n_fail++;
                    $display("FAIL dig4_reg dev%0d addr%h: got %h, required %h", c, ad, g_dut[1].devreg[c][ad], exp_reg(q, c, ad, 4));
                end
            end
    endtask

    task automatic test_reset_mid_frame;
        int         cyc, bf, ba;
        logic [4:0] obs;
        bf = g_dut[0].frames;
        ba = g_dut[0].aborted;
        pulse_upd(0);
        cyc = 0;
        while (!(g_dut[0].frames >= bf + 2 && g_dut[0].bits == 10 && g_dut[0].bus.load === 1'b0) && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL midframe_wait: bit %0d after %0d cycles, required 10", g_dut[0].bits, cyc);
        end
        rst = 1'b1;
        #1;
        obs = {g_dut[0].bus.sclk, g_dut[0].bus.load, g_dut[0].bus.sdo, g_dut[0].bus.busy, g_dut[0].bus.done};
        n_checks++;
        if (obs !== 5'b01010) begin
            n_fail++;
            $display("FAIL midframe_abort: sclk/load/sdo/busy/done=%b, required 01010", obs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (g_dut[0].frames < bf + 3 && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (g_dut[0].flog[bf+2] !== 32'h09000900 || g_dut[0].aborted - ba !== 1) begin
            n_fail++;
            $display("FAIL midframe_restart: frame %h aborted +%0d, required 09000900 +1", g_dut[0].flog[bf+2], g_dut[0].aborted - ba);
        end
        cyc = 0;
        while ((g_dut[0].bus.busy !== 1'b0 || g_dut[1].bus.busy !== 1'b0) && cyc < TIMEOUT) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT || g_dut[0].frames - bf !== 15) begin
            n_fail++;
            $display("FAIL midframe_reinit: frames +%0d after %0d cycles, required +15", g_dut[0].frames - bf, cyc);
        end
        for (int c = 0; c < 2; c++)
            for (int ad = 0; ad < 16; ad++) begin
                n_checks++;
                if (g_dut[0].devreg[c][ad] !== exp_reg(seg_drv[0], c, ad, 8)) begin
                    n_fail++;
                    $display("FAIL midframe_reg dev%0d addr%h: got %h, required %h", c, ad, g_dut[0].devreg[c][ad], exp_reg(seg_drv[0], c, ad, 8));
                end
            end
        n_checks++;
        if (g_dut[0].seen !== 16'h9FFE) begin
            n_fail++;
            $display("FAIL dig8_addr_set: got %h, required 9ffe", g_dut[0].seen);
        end
        n_checks++;
        if (g_dut[0].bad + g_dut[1].bad !== 0 || g_dut[0].sdo_idle + g_dut[1].sdo_idle !== 0) begin
            n_fail++;
            $display("FAIL framing_rules: bad %0d/%0d sdo_while_load_high %0d/%0d, required 0", g_dut[0].bad, g_dut[1].bad, g_dut[0].sdo_idle, g_dut[1].sdo_idle);
        end
    endtask

    initial begin
        logic [127:0] s0;
        s0 = '0;
        s0[63:56]   = 8'hA5;
        s0[127:120] = 8'h3C;
        seg_drv[0] = s0;
        seg_drv[1] = '0;
        upd_drv[0] = 1'b0;
        upd_drv[1] = 1'b0;
        rst = 1'b0;
        #2;
        test_reset();
        test_init();
        test_back_to_back();
        test_fin_request();
        test_digits4();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_chain_driver.md
SSEG_CHAIN_DRIVER -- requirements
Module: sseg_chain_driver

Interface
REQ-001 Parameter NCHIP, default 2, number of daisy-chained MAX7219 devices; legal range 1..8.
REQ-002 Parameter DIGITS, default 8, digits scanned per device (1..8); scan-limit register = DIGITS-1.
REQ-003 Parameter CLK_DIV, default 4, clk cycles per sclk half-period; legal range >=1.
REQ-004 Parameter INTENSITY, default 4'hF, intensity register value.
REQ-005 Parameter DECODE, default 8'h00, decode-mode register value.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 seg  input  NCHIP*64  segment data; device c, digit d (1..8) = seg[c*64+(d-1)*8 +: 8].
REQ-009 upd  input  1  refresh request, sampled every clk.
REQ-010 sclk  output  1  serial clock to device chain.
REQ-011 load  output  1  MAX7219 LOAD/CS; device latches on rising edge.
REQ-012 sdo  output  1  serial data to first device DIN.
REQ-013 busy  output  1  high while initialising or refreshing.
REQ-014 done  output  1  one-cycle pulse when a refresh completes.

Function
REQ-015 Frame = 16*NCHIP bits, MSB first; device NCHIP-1 (farthest) word shifted first, device 0 word last.
REQ-016 Word = {4'h0, addr[3:0], data[7:0]}.
REQ-017 Frame start: load falls low; each bit: sdo updated on entry to sclk-low phase, sclk low CLK_DIV cycles, then high CLK_DIV cycles.
REQ-018 After last bit's high phase: sclk low and load high on the same clk edge; load stays high >= CLK_DIV cycles before the next frame.
REQ-019 Frame duration with load low = 32*NCHIP*CLK_DIV cycles exactly; sdo = 0 whenever load is high.
REQ-020 States: INIT, IDLE, LATCH, DIG, FIN.
REQ-021 INIT sends five frames in order, same word to every device: addr 9 = DECODE, addr A = INTENSITY, addr B = DIGITS-1, addr F = 0x00, addr C = 0x01.
REQ-022 INIT -> LATCH after fifth frame (power-up refresh needs no upd).
REQ-023 LATCH: register seg into an internal copy in one cycle, clear pending flag, -> DIG with digit = 1.
REQ-024 DIG: one frame per digit d = 1..DIGITS, addr = d; device c data = latched copy byte for (c,d); seg changes during DIG have no effect.
REQ-025 After digit DIGITS frame and its load gap -> FIN; FIN asserts done for one cycle -> LATCH if pending set, else IDLE.
REQ-026 IDLE: upd=1 -> LATCH next cycle; sclk=0, load=1, busy=0.
REQ-027 upd=1 in any non-IDLE state sets pending flag; multiple requests collapse into one refresh; in-progress frame never aborted.
REQ-028 upd in FIN cycle sets pending and is serviced immediately (no request lost).
REQ-029 busy = 1 in INIT, LATCH, DIG, FIN; 0 only in IDLE.
REQ-030 Address 0 (no-op) never sent.

Reset
REQ-031 rst=1 immediately forces sclk=0, load=1, sdo=0, busy=1, done=0, pending=0, state INIT at first register, bit counters 0.
REQ-032 rst asserted mid-frame aborts the frame (load rises); after release INIT restarts from addr 9.
REQ-033 Latched segment copy is cleared to 0 on reset.

Verification
REQ-034 NCHIP=2, CLK_DIV=2, rst release -> 5 frames of 32 bits each, word pairs 0x0900/0x0900, 0x0A0F, 0x0B07, 0x0F00, 0x0C01; each load-low window exactly 128 cycles.
REQ-035 After init, seg[63:56]=8'hA5, seg[127:120]=8'h3C, rest 0 -> frame 8 carries words 0x083C then 0x08A5; done pulses once after frame 8.
REQ-036 upd pulsed 3 times during one refresh -> exactly one further refresh with values sampled at its LATCH; then busy=0.
REQ-037 DIGITS=4 -> scan-limit word 0x0B03; refresh sends addr 1..4 only; addr 0 and 5..8 never seen.
REQ-038 rst asserted at bit 10 of a digit frame -> load high, sclk low, sdo 0 in same cycle; after release first frame is 0x09 words.
REQ-039 Scoreboard models device shift chain and checks every latched register against expected values in all scenarios.
